// File: rtl/mmio_resp_pkg.sv
// mmio_resp_pkg: MMIO command field offsets and responder state type
package mmio_resp_pkg;
  localparam int WDATA_LSB = 0;
  typedef enum logic {IDLE, ISSUE} t_resp_state;
  function automatic int addr_lsb(input int data_w);
    return WDATA_LSB + data_w;
  endfunction
  function automatic int wr_bit(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction
  function automatic int rd_bit(input int addr_w, input int data_w);
    return data_w + addr_w + 1;
  endfunction
endpackage

// File: rtl/avst_mmio_avmm_responder_if.sv
// avst_mmio_avmm_responder_if: command/response streams + AVMM master bundle; master = responder side, slave = shim/fabric side
interface avst_mmio_avmm_responder_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 64
);
  logic [ADDR_W+DATA_W+1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        avm_address;
  logic                     avm_read;
  logic                     avm_write;
  logic [DATA_W-1:0]        avm_writedata;
  logic [DATA_W/8-1:0]      avm_byteenable;
  logic                     avm_waitrequest;
  logic [DATA_W-1:0]        avm_readdata;
  logic                     avm_readdatavalid;
  logic                     illegal_cmd;
  modport master (
    input  in_data, in_valid, out_ready, avm_waitrequest, avm_readdata, avm_readdatavalid,
    output in_ready, out_data, out_valid, avm_address, avm_read, avm_write, avm_writedata,
           avm_byteenable, illegal_cmd
  );
  modport slave (
    output in_data, in_valid, out_ready, avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  in_ready, out_data, out_valid, avm_address, avm_read, avm_write, avm_writedata,
           avm_byteenable, illegal_cmd
  );
endinterface

// File: rtl/mmio_rsp_fifo.sv
// mmio_rsp_fifo: registered show-ahead sync FIFO; ports clk, reset_n, push/push_data, pop/pop_data, count, empty, full
module mmio_rsp_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rp];
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= push_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(push_ok);
      rp    <= rp + AW'(pop_ok);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/avst_mmio_avmm_responder.sv
// avst_mmio_avmm_responder: MMIO command stream -> AVMM master, read data returned in order on out_*; ports clk, reset_n, bus (master modport); optional MMIO_RD_TIMEOUT_EN
module avst_mmio_avmm_responder
  import mmio_resp_pkg::*;
#(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 64,
  parameter int RSP_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset_n,
  avst_mmio_avmm_responder_if.master bus
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int AL = addr_lsb(DATA_W);
  localparam int WB = wr_bit(ADDR_W, DATA_W);
  localparam int RB = rd_bit(ADDR_W, DATA_W);
  t_resp_state state, state_n;
  logic run, credit, acc, cmd_rd, cmd_wr, issue_done, rd_retire, fifo_push, fifo_empty, fifo_full;
  logic [CW-1:0] pending, fifo_count;
  logic [DATA_W-1:0] fifo_din;
  assign cmd_rd     = bus.in_data[RB];
  assign cmd_wr     = bus.in_data[WB];
  assign credit     = ({1'b0, pending} + {1'b0, fifo_count}) < (CW+1)'(RSP_DEPTH);
  assign bus.in_ready = run && state == IDLE && credit;
  assign acc        = bus.in_valid && bus.in_ready;
  assign issue_done = state == ISSUE && !bus.avm_waitrequest;
  assign bus.avm_byteenable = '1;
  assign bus.out_valid = !fifo_empty;
  assign fifo_push  = rd_retire && !fifo_full;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (acc && (cmd_rd ^ cmd_wr) ? ISSUE : IDLE)
                            : (issue_done ? IDLE : ISSUE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state             <= IDLE;
      run               <= 1'b0;
      bus.avm_address   <= '0;
      bus.avm_writedata <= '0;
      bus.avm_read      <= 1'b0;
      bus.avm_write     <= 1'b0;
      bus.illegal_cmd   <= 1'b0;
      pending           <= '0;
    end else begin
      state           <= state_n;
      run             <= 1'b1;
      bus.illegal_cmd <= acc && !(cmd_rd ^ cmd_wr);
      if (state == IDLE && state_n == ISSUE) begin
        bus.avm_address   <= bus.in_data[AL +: ADDR_W];
        bus.avm_writedata <= bus.in_data[WDATA_LSB +: DATA_W];
        bus.avm_read      <= cmd_rd;
        bus.avm_write     <= cmd_wr;
      end
      if (issue_done) begin
        bus.avm_read  <= 1'b0;
        bus.avm_write <= 1'b0;
      end
      pending <= pending + CW'(issue_done && bus.avm_read) - CW'(rd_retire);
    end
`ifdef MMIO_RD_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt;
  logic [15:0] discard;
  logic live, late, tmo;
  // responses owed to timed-out reads are swallowed before any live data is accepted
  assign live      = bus.avm_readdatavalid && discard == '0 && pending != '0;
  assign late      = bus.avm_readdatavalid && discard != '0;
  assign tmo       = !bus.avm_readdatavalid && pending != '0 && tcnt == TCW'(TIMEOUT_CYCLES - 1);
  assign rd_retire = live || tmo;
  assign fifo_din  = tmo ? '1 : bus.avm_readdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tcnt    <= '0;
      discard <= '0;
    end else begin
      tcnt    <= pending == '0 || bus.avm_readdatavalid || tmo ? '0 : tcnt + 1'b1;
      discard <= discard + 16'(tmo) - 16'(late);
    end
`else
  assign rd_retire = bus.avm_readdatavalid && pending != '0;
  assign fifo_din  = bus.avm_readdata;
`endif
  mmio_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH), .CW(CW)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(fifo_din),
    .pop      (bus.out_valid && bus.out_ready),
    .pop_data (bus.out_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
endmodule
